// File: rtl/timer_dev.sv
// Programmable countdown timer on the CPU peripheral bus.
// Raises a masked interrupt on expiry, with either one-shot or auto-reload behaviour.
module timer_dev #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    localparam int unsigned TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [31:0]   preset_q, preset_d;
    logic [31:0]   count_q, count_d;
    logic          pend_q, pend_d;
    logic [TW-1:0] tick_q, tick_d;

    logic wr_ctrl, wr_preset;
    logic pend_set, pend_clr;

    assign wr_ctrl   = sel && we && (addr == 2'd0);
    assign wr_preset = sel && we && (addr == 2'd1);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;
        tick_d   = tick_q;
        pend_set = 1'b0;
        pend_clr = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ctrl_q[0]) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                tick_d  = '0;
                state_d = StCnt;
            end
            StCnt: begin
                if (!ctrl_q[0]) begin
                    state_d = StIdle;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    // A count of 0 or 1 expires on this tick; never wraps below zero.
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d  = 32'd0;
                        pend_set = 1'b1;
                        state_d  = StInt;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            StInt: begin
                if (ctrl_q[2:1] == 2'b01) begin
                    pend_clr = 1'b1;
                    state_d  = StLoad;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Bus writes are applied last so a CTRL write overrides the one-shot EN clear.
        if (wr_ctrl) begin
            ctrl_d = wd[3:0];
        end
        if (wr_preset) begin
            preset_d = wd;
        end

        // An expiry in the same cycle as a bus write keeps the interrupt.
        if (pend_set) begin
            pend_d = 1'b1;
        end else if (pend_clr || wr_ctrl || wr_preset) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            pend_q   <= 1'b0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        rd = 32'd0;
        if (sel) begin
            unique case (addr)
                2'd0:    rd = {28'd0, ctrl_q};
                2'd1:    rd = preset_q;
                2'd2:    rd = count_q;
                default: rd = 32'd0;
            endcase
        end
    end

    assign irq = pend_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: directed bus sequences push expected values into a scoreboard,
// and a negedge monitor pops and compares whenever a probe is active.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel0 = 1'b0;
    logic        sel1 = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    always #5 clk = ~clk;

    timer_dev u_dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel0),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd0),
        .irq   (irq0)
    );

    timer_dev #(
        .PRESCALE(4)
    ) u_dut_ps (
        .clk   (clk),
        .reset (reset),
        .sel   (sel1),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd1),
        .irq   (irq1)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic p_rd = 1'b0;
    logic p_irq = 1'b0;
    logic p_dev = 1'b0;
    logic fin_req = 1'b0;

    // Expected sequences, one entry per cycle after the enabling CTRL write.
    logic [31:0] os_cnt [10] = '{0, 0, 5, 4, 3, 2, 1, 0, 0, 0};
    logic        os_irq [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [31:0] ar_cnt [12] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
    logic        ar_irq [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    logic [31:0] mk_cnt [7]  = '{0, 0, 4, 3, 2, 1, 0};
    logic [31:0] pr_cnt [3]  = '{0, 0, 4};
    logic [31:0] re_cnt [3]  = '{2, 2, 4};
    logic        z0_irq [5]  = '{0, 0, 0, 1, 1};
    logic [31:0] mp_cnt [4]  = '{3, 2, 1, 0};
    logic        mp_irq [4]  = '{0, 0, 0, 1};
    logic [31:0] mx_cnt [4]  = '{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] ps_cnt [12] = '{0, 0, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
    logic        ps_irq [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    task automatic check(input logic [31:0] act);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty actual=%h", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.val) begin
                bad++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (p_rd) check(p_dev ? rd1 : rd0);
        if (p_irq) check({31'd0, p_dev ? irq1 : irq0});
        if (fin_req && sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
            sb.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wr(input logic dev, input logic [1:0] a, input logic [31:0] d);
        sel0 = !dev;
        sel1 = dev;
        we   = 1'b1;
        addr = a;
        wd   = d;
        step();
        sel0 = 1'b0;
        sel1 = 1'b0;
        we   = 1'b0;
        wd   = 32'd0;
    endtask

    // Probes the state left by the previous edge; the monitor samples at the next negedge.
    task automatic obs(input string name, input logic dev, input logic s, input logic [1:0] a,
                       input logic chk_rd, input logic [31:0] e_rd,
                       input logic chk_irq, input logic e_irq);
        exp_t e;
        sel0  = s && !dev;
        sel1  = s && dev;
        addr  = a;
        p_dev = dev;
        p_rd  = chk_rd;
        p_irq = chk_irq;
        if (chk_rd) begin
            e.name = {name, ".rd"};
            e.val  = e_rd;
            sb.push_back(e);
        end
        if (chk_irq) begin
            e.name = {name, ".irq"};
            e.val  = {31'd0, e_irq};
            sb.push_back(e);
        end
        step();
        sel0  = 1'b0;
        sel1  = 1'b0;
        p_rd  = 1'b0;
        p_irq = 1'b0;
    endtask

    initial begin
        do_reset();
        for (int a = 0; a < 4; a++) begin
            obs($sformatf("reset.addr%0d", a), 1'b0, 1'b1, 2'(a), 1'b1, 32'd0, 1'b1, 1'b0);
        end

        // One-shot, PRESET=5: irq rises 7 edges after the CTRL write and holds.
        do_reset();
        wr(1'b0, A_PRESET, 32'd5);
        wr(1'b0, A_CTRL, 32'h9);
        for (int k = 0; k < 10; k++) begin
            obs($sformatf("oneshot[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, os_cnt[k],
                1'b1, os_irq[k]);
        end
        obs("oneshot.ctrl", 1'b0, 1'b1, A_CTRL, 1'b1, 32'h8, 1'b1, 1'b1);
        wr(1'b0, A_CTRL, 32'h8);
        obs("oneshot.ack", 1'b0, 1'b1, A_CTRL, 1'b1, 32'h8, 1'b1, 1'b0);

        // Auto-reload, PRESET=3: 1-cycle pulses every 5 cycles.
        do_reset();
        wr(1'b0, A_PRESET, 32'd3);
        wr(1'b0, A_CTRL, 32'hB);
        for (int k = 0; k < 12; k++) begin
            obs($sformatf("reload[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, ar_cnt[k],
                1'b1, ar_irq[k]);
        end

        // Masked expiry, then pause and re-enable.
        do_reset();
        wr(1'b0, A_PRESET, 32'd4);
        wr(1'b0, A_CTRL, 32'h1);
        for (int k = 0; k < 7; k++) begin
            obs($sformatf("mask[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, mk_cnt[k], 1'b1, 1'b0);
        end
        obs("mask.ctrl", 1'b0, 1'b1, A_CTRL, 1'b1, 32'h0, 1'b1, 1'b0);
        wr(1'b0, A_CTRL, 32'h1);
        for (int k = 0; k < 3; k++) begin
            obs($sformatf("pause.run[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, pr_cnt[k],
                1'b0, 1'b0);
        end
        wr(1'b0, A_CTRL, 32'h0);
        for (int k = 0; k < 4; k++) begin
            obs($sformatf("pause.frozen[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, 32'd2,
                1'b0, 1'b0);
        end
        wr(1'b0, A_CTRL, 32'h1);
        for (int k = 0; k < 3; k++) begin
            obs($sformatf("reenable[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, re_cnt[k],
                1'b0, 1'b0);
        end

        // PRESET=0 behaves as 1: irq after 3 edges.
        do_reset();
        wr(1'b0, A_PRESET, 32'd0);
        wr(1'b0, A_CTRL, 32'h9);
        for (int k = 0; k < 5; k++) begin
            obs($sformatf("preset0[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, 32'd0,
                1'b1, z0_irq[k]);
        end

        // PRESET write mid-count does not disturb the running sequence.
        do_reset();
        wr(1'b0, A_PRESET, 32'd5);
        wr(1'b0, A_CTRL, 32'h9);
        for (int k = 0; k < 3; k++) begin
            obs($sformatf("midp.pre[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, os_cnt[k],
                1'b0, 1'b0);
        end
        wr(1'b0, A_PRESET, 32'd100);
        for (int k = 0; k < 4; k++) begin
            obs($sformatf("midp.post[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, mp_cnt[k],
                1'b1, mp_irq[k]);
        end
        obs("midp.preset", 1'b0, 1'b1, A_PRESET, 1'b1, 32'd100, 1'b1, 1'b1);
        obs("nosel", 1'b0, 1'b0, A_PRESET, 1'b1, 32'd0, 1'b0, 1'b0);

        // Largest PRESET counts down without wrapping.
        do_reset();
        wr(1'b0, A_PRESET, 32'hFFFF_FFFF);
        wr(1'b0, A_CTRL, 32'h1);
        for (int k = 0; k < 4; k++) begin
            obs($sformatf("maxpre[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, mx_cnt[k],
                1'b0, 1'b0);
        end

        // Reset mid-count.
        do_reset();
        wr(1'b0, A_PRESET, 32'd5);
        wr(1'b0, A_CTRL, 32'h9);
        for (int k = 0; k < 4; k++) begin
            obs($sformatf("midrst.pre[%0d]", k), 1'b0, 1'b1, A_COUNT, 1'b1, os_cnt[k],
                1'b0, 1'b0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        obs("midrst.count", 1'b0, 1'b1, A_COUNT, 1'b1, 32'd0, 1'b1, 1'b0);
        obs("midrst.ctrl", 1'b0, 1'b1, A_CTRL, 1'b1, 32'd0, 1'b0, 1'b0);

        // PRESCALE=4, PRESET=2: one decrement per 4 cycles, irq 8 cycles after LOAD.
        do_reset();
        wr(1'b1, A_PRESET, 32'd2);
        wr(1'b1, A_CTRL, 32'h9);
        for (int k = 0; k < 12; k++) begin
            obs($sformatf("prescale[%0d]", k), 1'b1, 1'b1, A_COUNT, 1'b1, ps_cnt[k],
                1'b1, ps_irq[k]);
        end

        fin_req = 1'b1;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
